if_fetch_stage: RTL and testbench

Instruction-fetch stage of the 5-stage MIPS-32 pipeline. It owns the program counter, drives the instruction-memory address, computes next-PC (sequential, taken branch, jump), and holds the IF/ID pipeline register. It sits directly upstream of the lw-use stall instruction mux and the decode stage. It honours `lw_use_control_stall` by freezing the PC and IF/ID, and flushes IF/ID on control redirects.

---
 rtl/mips_pkg.sv | 18 +
 rtl/pc_next_sel.sv | 30 +++
 rtl/if_fetch_stage.sv | 112 +++++++++++
 tb/tb_if_fetch_stage.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared MIPS-32 pipeline definitions: NOP encoding, default reset PC,
// fetch-stage state encoding and word-alignment helper.
package mips_pkg;

   localparam logic [31:0] NOP_INSTR        = 32'h0000_0000;
   localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

   typedef enum logic [1:0] {
      FS_BOOT    = 2'd0,
      FS_RUN     = 2'd1,
      FS_STALLED = 2'd2
   } fetch_state_e;

   function automatic logic [31:0] word_align(input logic [31:0] addr);
      return {addr[31:2], 2'b00};
   endfunction

endpackage

// File: rtl/pc_next_sel.sv
// Next-PC priority mux: stall hold > taken branch > jump > PC+4.
// Redirect targets are forced word-aligned.
module pc_next_sel
   import mips_pkg::*;
(
   input  logic [31:0] pc,
   input  logic        stall,
   input  logic        branch_taken,
   input  logic [31:0] branch_target,
   input  logic        jump,
   input  logic [31:0] jump_target,
   output logic [31:0] pc_next,
   output logic [31:0] pc_plus4,
   output logic        redirect
);

   always_comb begin
      pc_plus4 = pc + 32'd4;
      redirect = !stall && (branch_taken || jump);
      pc_next  = pc_plus4;
      if (stall) begin
         pc_next = pc;
      end else if (branch_taken) begin
         pc_next = word_align(branch_target);
      end else if (jump) begin
         pc_next = word_align(jump_target);
      end
   end

endmodule

// File: rtl/if_fetch_stage.sv
// MIPS-32 instruction-fetch stage: PC register, IF/ID pipeline register,
// fetch FSM and saturating stall/redirect event counters.
module if_fetch_stage
   import mips_pkg::*;
#(
   parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
   parameter int unsigned CNT_W    = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              lw_use_control_stall,
   input  logic              branch_taken,
   input  logic [31:0]       branch_target,
   input  logic              jump,
   input  logic [31:0]       jump_target,
   output logic [31:0]       imem_addr,
   input  logic [31:0]       imem_rdata,
   output logic [31:0]       if_id_instr,
   output logic [31:0]       if_id_pc_plus4,
   output logic              if_id_valid,
   output logic [1:0]        fetch_state,
   output logic [CNT_W-1:0]  stall_count,
   output logic [CNT_W-1:0]  flush_count
);

   logic [31:0]      pc_q, pc_d;
   logic [31:0]      instr_q, instr_d;
   logic [31:0]      pc4_q, pc4_d;
   logic             valid_q, valid_d;
   fetch_state_e     state_q, state_d;
   logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
   logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

   logic [31:0] pc_next;
   logic [31:0] pc_plus4;
   logic        redirect;

   pc_next_sel u_pc_next_sel (
      .pc            (pc_q),
      .stall         (lw_use_control_stall),
      .branch_taken  (branch_taken),
      .branch_target (branch_target),
      .jump          (jump),
      .jump_target   (jump_target),
      .pc_next       (pc_next),
      .pc_plus4      (pc_plus4),
      .redirect      (redirect)
   );

   always_comb begin
      pc_d        = pc_next;
      instr_d     = instr_q;
      pc4_d       = pc4_q;
      valid_d     = valid_q;
      stall_cnt_d = stall_cnt_q;
      flush_cnt_d = flush_cnt_q;

      if (lw_use_control_stall) begin
         if (stall_cnt_q != '1) stall_cnt_d = stall_cnt_q + CNT_W'(1);
      end else if (redirect) begin
         instr_d = NOP_INSTR;
         pc4_d   = '0;
         valid_d = 1'b0;
         if (flush_cnt_q != '1) flush_cnt_d = flush_cnt_q + CNT_W'(1);
      end else begin
         instr_d = imem_rdata;
         pc4_d   = pc_plus4;
         valid_d = 1'b1;
      end
   end

   // BOOT leaves unconditionally on the first live edge; the stall still
   // freezes PC/IF/ID through the datapath above.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         FS_BOOT:    state_d = FS_RUN;
         FS_RUN:     state_d = lw_use_control_stall ? FS_STALLED : FS_RUN;
         FS_STALLED: state_d = lw_use_control_stall ? FS_STALLED : FS_RUN;
         default:    state_d = FS_BOOT;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         pc_q        <= RESET_PC;
         instr_q     <= NOP_INSTR;
         pc4_q       <= '0;
         valid_q     <= 1'b0;
         state_q     <= FS_BOOT;
         stall_cnt_q <= '0;
         flush_cnt_q <= '0;
      end else begin
         pc_q        <= pc_d;
         instr_q     <= instr_d;
         pc4_q       <= pc4_d;
         valid_q     <= valid_d;
         state_q     <= state_d;
         stall_cnt_q <= stall_cnt_d;
         flush_cnt_q <= flush_cnt_d;
      end
   end

   assign imem_addr      = pc_q;
   assign if_id_instr    = instr_q;
   assign if_id_pc_plus4 = pc4_q;
   assign if_id_valid    = valid_q;
   assign fetch_state    = state_q;
   assign stall_count    = stall_cnt_q;
   assign flush_count    = flush_cnt_q;

endmodule

// File: tb/tb_if_fetch_stage.sv
// Scoreboard bench for if_fetch_stage: a cycle model pushes expected
// outputs per driven cycle; each scenario task drains and compares them.
module tb_if_fetch_stage;

   typedef struct packed {
      logic [31:0] addr;
      logic [31:0] instr;
      logic [31:0] pc4;
      logic        valid;
      logic [1:0]  state;
      logic [15:0] scnt;
      logic [15:0] fcnt;
   } snap_t;

   logic        clk;
   logic        rst_n;
   logic        stall;
   logic        br;
   logic [31:0] bt;
   logic        jmp;
   logic [31:0] jt;

   logic [31:0] imem_addr, imem_rdata, if_id_instr, if_id_pc_plus4;
   logic        if_id_valid;
   logic [1:0]  fetch_state;
   logic [15:0] stall_count, flush_count;

   logic [31:0] addr2, rdata2, instr2, pc42;
   logic        valid2;
   logic [1:0]  state2;
   logic [2:0]  scnt2, fcnt2;

   snap_t exp_q[$];
   snap_t obs_q[$];
   int    n_cmp = 0;
   int    n_bad = 0;

   logic [31:0] m_pc, m_instr, m_pc4;
   logic        m_valid;
   logic [1:0]  m_state;
   logic [15:0] m_s, m_f;

   if_fetch_stage #(.RESET_PC(32'h0000_0000), .CNT_W(16)) dut (
      .clk                  (clk),
      .rst_n                (rst_n),
      .lw_use_control_stall (stall),
      .branch_taken         (br),
      .branch_target        (bt),
      .jump                 (jmp),
      .jump_target          (jt),
      .imem_addr            (imem_addr),
      .imem_rdata           (imem_rdata),
      .if_id_instr          (if_id_instr),
      .if_id_pc_plus4       (if_id_pc_plus4),
      .if_id_valid          (if_id_valid),
      .fetch_state          (fetch_state),
      .stall_count          (stall_count),
      .flush_count          (flush_count)
   );

   if_fetch_stage #(.RESET_PC(32'hFFFF_FFFC), .CNT_W(3)) dut2 (
      .clk                  (clk),
      .rst_n                (rst_n),
      .lw_use_control_stall (stall),
      .branch_taken         (br),
      .branch_target        (bt),
      .jump                 (jmp),
      .jump_target          (jt),
      .imem_addr            (addr2),
      .imem_rdata           (rdata2),
      .if_id_instr          (instr2),
      .if_id_pc_plus4       (pc42),
      .if_id_valid          (valid2),
      .fetch_state          (state2),
      .stall_count          (scnt2),
      .flush_count          (fcnt2)
   );

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      case (a)
         32'h0000_0000: return 32'h2008_0005;
         32'h0000_0004: return 32'h2009_0003;
         default:       return {16'hC0DE, a[15:0]};
      endcase
   endfunction

   assign imem_rdata = mem_word(imem_addr);
   assign rdata2     = mem_word(addr2);

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic drive_cycle(input logic r, input logic s, input logic b,
                              input logic [31:0] btg, input logic j,
                              input logic [31:0] jtg);
      snap_t      e;
      logic [1:0] nstate;
      rst_n = r; stall = s; br = b; bt = btg; jmp = j; jt = jtg;
      if (!r) begin
         m_pc = 32'h0; m_instr = 32'h0; m_pc4 = 32'h0; m_valid = 1'b0;
         m_state = 2'd0; m_s = 16'h0; m_f = 16'h0;
      end else begin
         nstate = (m_state == 2'd0) ? 2'd1 : (s ? 2'd2 : 2'd1);
         if (s) begin
            if (m_s != 16'hFFFF) m_s = m_s + 16'd1;
         end else if (b || j) begin
            m_pc    = (b ? btg : jtg) & 32'hFFFF_FFFC;
            m_instr = 32'h0; m_pc4 = 32'h0; m_valid = 1'b0;
            if (m_f != 16'hFFFF) m_f = m_f + 16'd1;
         end else begin
            m_instr = mem_word(m_pc);
            m_pc    = m_pc + 32'd4;
            m_pc4   = m_pc;
            m_valid = 1'b1;
         end
         m_state = nstate;
      end
      e = '{m_pc, m_instr, m_pc4, m_valid, m_state, m_s, m_f};
      exp_q.push_back(e);
      @(posedge clk);
      #1;
      obs_q.push_back('{imem_addr, if_id_instr, if_id_pc_plus4, if_id_valid,
                        fetch_state, stall_count, flush_count});
   endtask

   task automatic seq(input int unsigned n);
      for (int unsigned i = 0; i < n; i++) drive_cycle(1, 0, 0, 0, 0, 0);
   endtask

   task automatic test_reset;
      snap_t e, o;
      drive_cycle(0, 1, 1, 32'h40, 1, 32'h80);
      drive_cycle(0, 0, 0, 0, 0, 0);
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front(); o = obs_q.pop_front(); n_cmp++;
         if (o !== e) begin
            n_bad++;
            $display("FAIL reset: got %h want %h", o, e);
         end
      end
   endtask

   task automatic test_sequential;
      snap_t e, o;
      seq(2);
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front(); o = obs_q.pop_front(); n_cmp++;
         if (o !== e) begin
            n_bad++;
            $display("FAIL sequential: got %h want %h", o, e);
         end
      end
   endtask

   task automatic test_stall;
      snap_t e, o;
      drive_cycle(1, 1, 0, 0, 0, 0);
      drive_cycle(1, 1, 0, 0, 0, 0);
      seq(2);
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front(); o = obs_q.pop_front(); n_cmp++;
         if (o !== e) begin
            n_bad++;
            $display("FAIL stall: got %h want %h", o, e);
         end
      end
   endtask

   task automatic test_branch;
      snap_t e, o;
      drive_cycle(1, 0, 1, 32'h40, 0, 0);
      seq(2);
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front(); o = obs_q.pop_front(); n_cmp++;
         if (o !== e) begin
            n_bad++;
            $display("FAIL branch: got %h want %h", o, e);
         end
      end
   endtask

   task automatic test_priority;
      snap_t e, o;
      drive_cycle(1, 0, 1, 32'h80, 1, 32'h100);
      seq(1);
      drive_cycle(1, 1, 1, 32'h200, 1, 32'h300);
      drive_cycle(1, 1, 0, 0, 1, 32'h300);
      seq(2);
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front(); o = obs_q.pop_front(); n_cmp++;
         if (o !== e) begin
            n_bad++;
            $display("FAIL priority: got %h want %h", o, e);
         end
      end
   endtask

   task automatic test_back_to_back;
      snap_t e, o;
      drive_cycle(1, 0, 0, 0, 1, 32'h103);
      drive_cycle(1, 0, 1, 32'h1002, 0, 0);
      drive_cycle(1, 0, 0, 0, 1, 32'h2001);
      seq(3);
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front(); o = obs_q.pop_front(); n_cmp++;
         if (o !== e) begin
            n_bad++;
            $display("FAIL back_to_back: got %h want %h", o, e);
         end
      end
   endtask

   task automatic test_reset_mid_stall;
      snap_t e, o;
      drive_cycle(0, 0, 0, 0, 0, 0);
      seq(1);
      for (int unsigned i = 0; i < 5; i++) drive_cycle(1, 1, 0, 0, 0, 0);
      drive_cycle(0, 1, 1, 32'h40, 0, 0);
      seq(1);
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front(); o = obs_q.pop_front(); n_cmp++;
         if (o !== e) begin
            n_bad++;
            $display("FAIL reset_mid_stall: got %h want %h", o, e);
         end
      end
   endtask

   task automatic test_wrap_saturate;
      snap_t       e, o;
      logic [31:0] want_instr;
      want_instr = mem_word(32'hFFFF_FFFC);
      drive_cycle(0, 0, 0, 0, 0, 0);
      n_cmp++;
      if (addr2 !== 32'hFFFF_FFFC) begin
         n_bad++; $display("FAIL wrap_reset_pc: got %h want fffffffc", addr2);
      end
      seq(1);
      n_cmp++;
      if ({addr2, pc42, instr2, valid2} !== {32'h0, 32'h0, want_instr, 1'b1}) begin
         n_bad++;
         $display("FAIL wrap_pc: got addr %h pc4 %h instr %h v %b want 0 0 %h 1",
                  addr2, pc42, instr2, valid2, want_instr);
      end
      for (int unsigned i = 0; i < 9; i++) drive_cycle(1, 1, 0, 0, 0, 0);
      n_cmp++;
      if ({scnt2, state2} !== {3'd7, 2'd2}) begin
         n_bad++; $display("FAIL stall_sat: got cnt %0d state %0d want 7 2", scnt2, state2);
      end
      for (int unsigned i = 0; i < 9; i++) drive_cycle(1, 0, 1, 32'h40 + 32'(i * 8), 0, 0);
      n_cmp++;
      if ({fcnt2, scnt2, valid2, addr2} !== {3'd7, 3'd7, 1'b0, 32'h80}) begin
         n_bad++;
         $display("FAIL flush_sat: got fcnt %0d scnt %0d v %b addr %h want 7 7 0 00000080",
                  fcnt2, scnt2, valid2, addr2);
      end
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front(); o = obs_q.pop_front(); n_cmp++;
         if (o !== e) begin
            n_bad++;
            $display("FAIL wrap_main: got %h want %h", o, e);
         end
      end
   endtask

   initial begin
      rst_n = 1'b0; stall = 1'b0; br = 1'b0; bt = '0; jmp = 1'b0; jt = '0;
      m_pc = '0; m_instr = '0; m_pc4 = '0; m_valid = 1'b0;
      m_state = '0; m_s = '0; m_f = '0;
      #2;
      test_reset;
      test_sequential;
      test_stall;
      test_branch;
      test_priority;
      test_back_to_back;
      test_reset_mid_stall;
      test_wrap_saturate;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
